// File: rtl/burst_rr_arbiter_pkg.sv
// Shared types and helpers for the burst round-robin arbiter.
// The search helper is sized for the largest supported requester count.
package burst_rr_arbiter_pkg;

  localparam int MAX_N = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // First set bit of e searching upward from ptr, wrapping n-1 -> 0.
  // Returns 0 when e is empty; callers qualify with |e.
  function automatic int rr_first_from(input logic [MAX_N-1:0] e,
                                       input logic [3:0]       ptr,
                                       input int               n);
    int idx;
    int pos;
    idx = 0;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        pos = (int'(ptr) + k) % n;
        if (e[pos[3:0]]) idx = pos;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/burst_rr_arbiter_if.sv
// Requester/resource handshake bundle for the burst round-robin arbiter.
// master = requester/resource side, slave = arbiter side.
interface burst_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int QW = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*QW-1:0] quota;
  logic            beat;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_id;
  logic            busy;

  modport master (
    output req, last, quota, beat,
    input  grant, grant_id, busy
  );

  modport slave (
    input  req, last, quota, beat,
    output grant, grant_id, busy
  );
endinterface

// File: rtl/burst_rr_arbiter_rr_pick.sv
// Combinational wrap-around winner selection from an eligibility vector.
// Outputs are unregistered; the instantiating block registers them.
module rr_pick
  import burst_rr_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_e,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx
);

  assign o_idx = IW'(rr_first_from(MAX_N'(i_e), 4'(i_ptr), N));

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign o_onehot[gi] = (|i_e) && (o_idx == IW'(gi));
  end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter granting bursts bounded by a per-requester beat quota,
// with early release on last or request drop and one dead cycle between tenures.
module burst_rr_arbiter
  import burst_rr_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int QW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  burst_rr_arbiter_if.slave   bus
);

  state_t        r_state;
  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_grant_id;
  logic [IW-1:0] r_ptr;
  logic [QW-1:0] r_cnt;

  state_t        w_state_next;
  logic [N-1:0]  w_grant_next;
  logic [IW-1:0] w_id_next;
  logic [IW-1:0] w_ptr_next;
  logic [QW-1:0] w_cnt_next;

  logic [QW-1:0] w_quota_arr [N];
  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_win_oh;
  logic [IW-1:0] w_win_idx;
  logic          w_end;

  for (genvar gi = 0; gi < N; gi++) begin : g_elig
    assign w_quota_arr[gi] = bus.quota[gi*QW +: QW];
    assign w_elig[gi]      = bus.req[gi] && (w_quota_arr[gi] != '0);
  end

  rr_pick #(.N(N)) u_pick (
    .i_e      (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx)
  );

  // Any combination of end conditions collapses into one release.
  assign w_end = (bus.beat && bus.last[r_grant_id])
              || (bus.beat && (r_cnt == QW'(1)))
              || !bus.req[r_grant_id];

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_id_next    = r_grant_id;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (|w_elig) begin
          w_state_next = OWN;
          w_grant_next = w_win_oh;
          w_id_next    = w_win_idx;
          w_cnt_next   = w_quota_arr[w_win_idx];
        end
      end
      OWN: begin
        if (w_end) begin
          w_state_next = IDLE;
          w_grant_next = '0;
          w_id_next    = '0;
          w_cnt_next   = '0;
          w_ptr_next   = (r_grant_id == IW'(N - 1)) ? '0 : r_grant_id + IW'(1);
        end else if (bus.beat) begin
          w_cnt_next = r_cnt - QW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_grant_id <= w_id_next;
      r_ptr      <= w_ptr_next;
      r_cnt      <= w_cnt_next;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = (r_state == OWN);

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, and random
// stimulus against a tenure-level reference model.
module tb_burst_rr_arbiter;
  localparam int N  = 4;
  localparam int QW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_rr_arbiter_if #(.N(N), .QW(QW)) bus ();
  burst_rr_arbiter #(.N(N), .QW(QW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the resource, how many beats taken vs allowed.
  int m_owner = -1;
  int m_taken = 0;
  int m_limit = 0;
  int m_ptr   = 0;

  typedef struct {
    logic        r;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [15:0] quota;
    logic        beat;
    logic [3:0]  eg;
    logic [1:0]  eid;
    logic        eb;
  } vec_t;
  vec_t tbl[16];

  function automatic int slice_of(input logic [15:0] q, input int i);
    return int'((q >> (i * QW)) & 16'h000f);
  endfunction

  function automatic void model_step(input logic r, input logic [3:0] rq,
                                     input logic [3:0] ls, input logic [15:0] q,
                                     input logic b);
    bit done;
    int c;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_taken = 0; m_limit = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (m_owner < 0 && rq[c] && slice_of(q, c) != 0) begin
          m_owner = c; m_limit = slice_of(q, c); m_taken = 0;
        end
      end
    end else begin
      done = !rq[m_owner];
      if (b) begin
        m_taken++;
        if (ls[m_owner] || m_taken == m_limit) done = 1'b1;
      end
      if (done) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endfunction

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                     input logic [15:0] q, input logic b);
    rst = r; bus.req = rq; bus.last = ls; bus.quota = q; bus.beat = b;
    model_step(r, rq, ls, q, b);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] eg, input logic [1:0] eid,
                     input logic eb);
    checks++;
    if (bus.grant !== eg || bus.grant_id !== eid || bus.busy !== eb) begin
      errors++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b, need grant=%b id=%0d busy=%b",
               nm, bus.grant, bus.grant_id, bus.busy, eg, eid, eb);
    end else begin
      $display("ok   %s: grant=%b id=%0d busy=%b", nm, bus.grant, bus.grant_id, bus.busy);
    end
  endtask

  task automatic chk_model(input string nm);
    logic [3:0] eg;
    logic [1:0] eid;
    eg  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    chk(nm, eg, eid, m_owner >= 0);
  endtask

  logic [3:0]  r_req;
  logic [3:0]  r_last;
  logic [15:0] r_quota;
  logic        r_beat;
  logic        r_rst;

  initial begin
    bus.req = '0; bus.last = '0; bus.quota = '0; bus.beat = 1'b0;

    // Single requester, quota 3, then fair rotation with quota 1 each.
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 16'h0003, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0000, 16'h0003, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 16'h0003, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0000, 16'h0003, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[4]  = '{1'b0, 4'b0001, 4'b0000, 16'h0003, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0001, 4'b0000, 16'h0003, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[6]  = '{1'b1, 4'b1111, 4'b0000, 16'h1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 16'h1111, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[8]  = '{1'b0, 4'b1111, 4'b0000, 16'h1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 4'b1111, 4'b0000, 16'h1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 4'b1111, 4'b0000, 16'h1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 4'b1111, 4'b0000, 16'h1111, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[12] = '{1'b0, 4'b1111, 4'b0000, 16'h1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[13] = '{1'b0, 4'b1111, 4'b0000, 16'h1111, 1'b1, 4'b1000, 2'd3, 1'b1};
    tbl[14] = '{1'b0, 4'b1111, 4'b0000, 16'h1111, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[15] = '{1'b0, 4'b1111, 4'b0000, 16'h1111, 1'b1, 4'b0001, 2'd0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].r, tbl[i].req, tbl[i].last, tbl[i].quota, tbl[i].beat);
      chk($sformatf("vec%0d", i), tbl[i].eg, tbl[i].eid, tbl[i].eb);
    end

    // Early last on the 2nd beat; a non-granted last is ignored; ptr lands on 2.
    cyc(1, 4'b0000, 4'b0000, 16'h0080, 0);
    cyc(0, 4'b0010, 4'b0000, 16'h0080, 1); chk("early_grant", 4'b0010, 2'd1, 1);
    cyc(0, 4'b0010, 4'b0001, 16'h0080, 1); chk("early_beat1", 4'b0010, 2'd1, 1);
    cyc(0, 4'b0010, 4'b0010, 16'h0080, 1); chk("early_drop", 4'b0000, 2'd0, 0);
    cyc(0, 4'b0011, 4'b0000, 16'h0081, 0); chk("early_wrap", 4'b0001, 2'd0, 1);

    // Request drop mid-tenure, then a disabled requester.
    cyc(1, 4'b0000, 4'b0000, 16'h0100, 0);
    cyc(0, 4'b0100, 4'b0000, 16'h0100, 0); chk("drop_grant", 4'b0100, 2'd2, 1);
    cyc(0, 4'b0100, 4'b0000, 16'h0100, 0); chk("drop_hold", 4'b0100, 2'd2, 1);
    cyc(0, 4'b0000, 4'b0000, 16'h0100, 0); chk("drop_rel", 4'b0000, 2'd0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'b1000, 4'b0000, 16'h0100, 1); chk($sformatf("disabled%0d", i), 4'b0000, 2'd0, 0);
    end

    // All end conditions at once: one release, ptr moves to 3.
    cyc(1, 4'b0000, 4'b0000, 16'h0100, 0);
    cyc(0, 4'b0100, 4'b0000, 16'h0100, 0); chk("simul_grant", 4'b0100, 2'd2, 1);
    cyc(0, 4'b0000, 4'b0100, 16'h0100, 1); chk("simul_rel", 4'b0000, 2'd0, 0);
    cyc(0, 4'b1111, 4'b0000, 16'h1111, 0); chk("simul_next", 4'b1000, 2'd3, 1);

    // Reset mid-tenure with counter at 5; quota change during OWN is ignored.
    cyc(1, 4'b0000, 4'b0000, 16'h0008, 0);
    cyc(0, 4'b0001, 4'b0000, 16'h0008, 1); chk("mid_grant", 4'b0001, 2'd0, 1);
    cyc(0, 4'b0001, 4'b0000, 16'h0001, 1); chk("mid_b1", 4'b0001, 2'd0, 1);
    cyc(0, 4'b0001, 4'b0000, 16'h0001, 1); chk("mid_b2", 4'b0001, 2'd0, 1);
    cyc(0, 4'b0001, 4'b0000, 16'h0008, 1); chk("mid_b3", 4'b0001, 2'd0, 1);
    cyc(1, 4'b0001, 4'b0000, 16'h0008, 1); chk("mid_rst", 4'b0000, 2'd0, 0);
    cyc(0, 4'b0110, 4'b0000, 16'h0880, 0); chk("mid_after", 4'b0010, 2'd1, 1);

    // Random traffic against the model.
    r_quota = 16'h2531;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < N; k++) r_quota[k*QW +: QW] = 4'($urandom_range(0, 5));
      end
      for (int k = 0; k < N; k++) begin
        r_req[k]  = ($urandom_range(0, 3) != 0);
        r_last[k] = ($urandom_range(0, 3) == 0);
      end
      r_beat = 1'($urandom_range(0, 1));
      r_rst  = ($urandom_range(0, 63) == 0);
      cyc(r_rst, r_req, r_last, r_quota, r_beat);
      chk_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
